// File: rtl/cpu.sv
// rtl/cpu.sv - 16-bit accumulator CPU: internal ROM/RAM, 3-cycle FETCH/DECODE/EXEC, strobed I/O bus
// Define CPU_IN_EN to enable the IN instruction (op E); otherwise op E is a NOP and DO stays low.
module cpu #(
    parameter INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset_bar,
    output logic [15:0] addr,
    inout  wire  [15:0] bus,
    output logic        DI,
    output logic        DO
);
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_CMPI = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_ADD  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_AND  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JNZ  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_IN   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Built-in image: count 0..24 out of port 0, then halt.
    logic [15:0] rom [0:255] = '{0: 16'h1000, 1: 16'hD000, 2: 16'h2001, 3: 16'h4019,
                                 4: 16'hC001, 5: 16'hF000, default: 16'h0000};
    logic [15:0] ram [0:255];

    state_t      state, state_next;
    logic [7:0]  pc, pc_next;
    logic [15:0] ir, a, a_next;
    logic        z, z_next;
    logic        di_next, do_next, ram_we, load_z;

    logic [3:0]  op;
    logic [15:0] imm16;
    logic [7:0]  maddr;
    logic [15:0] mem;

    assign op    = ir[15:12];
    assign imm16 = {4'h0, ir[11:0]};
    assign maddr = ir[7:0];
    assign mem   = ram[maddr];

    // IR still holds the HLT word while halted, so addr naturally holds its last value.
    assign addr = (state == S_FETCH) ? {8'h00, pc} : imm16;
    assign bus  = DI ? a : 16'hzzzz;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        a_next     = a;
        z_next     = z;
        di_next    = 1'b0;
        do_next    = 1'b0;
        ram_we     = 1'b0;
        load_z     = 1'b0;
        case (state)
            S_FETCH: begin
                state_next = S_DECODE;
                pc_next    = pc + 8'd1;
            end
            S_DECODE: begin
                state_next = S_EXEC;
                // Strobes are registered here so they are clean for exactly the EXEC cycle.
                di_next    = (op == OP_OUT);
`ifdef CPU_IN_EN
                do_next    = (op == OP_IN);
`endif
            end
            S_EXEC: begin
                state_next = S_FETCH;
                case (op)
                    OP_LDI:  begin a_next = imm16;     load_z = 1'b1; end
                    OP_ADDI: begin a_next = a + imm16; load_z = 1'b1; end
                    OP_SUBI: begin a_next = a - imm16; load_z = 1'b1; end
                    OP_CMPI: z_next = (a == imm16);
                    OP_LD:   begin a_next = mem;       load_z = 1'b1; end
                    OP_ST:   ram_we = 1'b1;
                    OP_ADD:  begin a_next = a + mem;   load_z = 1'b1; end
                    OP_SUB:  begin a_next = a - mem;   load_z = 1'b1; end
                    OP_AND:  begin a_next = a & mem;   load_z = 1'b1; end
                    OP_JMP:  pc_next = maddr;
                    OP_JZ:   if (z)  pc_next = maddr;
                    OP_JNZ:  if (!z) pc_next = maddr;
`ifdef CPU_IN_EN
                    OP_IN:   begin a_next = bus;       load_z = 1'b1; end
`endif
                    OP_HLT:  state_next = S_HALT;
                    default: ;
                endcase
                if (load_z) z_next = (a_next == 16'h0000);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state <= S_FETCH;
            pc    <= 8'h00;
            ir    <= 16'h0000;
            a     <= 16'h0000;
            z     <= 1'b0;
            DI    <= 1'b0;
            DO    <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            a     <= a_next;
            z     <= z_next;
            DI    <= di_next;
            DO    <= do_next;
            if (state == S_FETCH) ir <= rom[pc];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[maddr] <= a;
    end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - self-checking bench for cpu: ISA-level reference model, directed and random programs
module tb_cpu;
    logic        clk = 1'b0;
    logic        reset_bar = 1'b0;
    logic [15:0] addr;
    wire  [15:0] bus;
    logic        DI, DO;
    logic [15:0] dev_data = 16'h5A3C;

    // Device side drives the bus whenever the CPU is not writing it.
    assign bus = DI ? 16'hzzzz : dev_data;

    cpu dut (.clk(clk), .reset_bar(reset_bar), .addr(addr), .bus(bus), .DI(DI), .DO(DO));

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] port;
        logic [15:0] val;
    } ev_t;

    ev_t         got_ev[$];
    ev_t         exp_ev[$];
    int          got_do[$];
    int          exp_do[$];
    logic [15:0] prog [0:255];
    logic [15:0] exp_halt_addr;
    bit          exp_halted;
    int          nodrive_err, excl_err;
    int          passed = 0;
    int          total = 0;
    int          steps;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] imm);
        return {op, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    // Instruction-level interpreter: OUT/IN of the j-th executed instruction lands on cycle 3j+2.
    task automatic model(output int nsteps);
        logic [15:0] ma, w, imm;
        logic [15:0] mram [0:255];
        logic [7:0]  mpc, m;
        logic        mz;
        ev_t         e;
        ma = 0; mz = 0; mpc = 0; nsteps = 0;
        for (int i = 0; i < 256; i++) mram[i] = 16'h0000;
        exp_ev.delete(); exp_do.delete(); exp_halted = 0; exp_halt_addr = 0;
        for (int j = 0; j < 1000; j++) begin
            w = prog[mpc];
            mpc = mpc + 8'd1;
            imm = {4'h0, w[11:0]};
            m = w[7:0];
            nsteps = j + 1;
            case (w[15:12])
                4'h1: begin ma = imm;            mz = (ma == 0); end
                4'h2: begin ma = ma + imm;       mz = (ma == 0); end
                4'h3: begin ma = ma - imm;       mz = (ma == 0); end
                4'h4: mz = (ma == imm);
                4'h5: begin ma = mram[m];        mz = (ma == 0); end
                4'h6: mram[m] = ma;
                4'h7: begin ma = ma + mram[m];   mz = (ma == 0); end
                4'h8: begin ma = ma - mram[m];   mz = (ma == 0); end
                4'h9: begin ma = ma & mram[m];   mz = (ma == 0); end
                4'hA: mpc = m;
                4'hB: if (mz) mpc = m;
                4'hC: if (!mz) mpc = m;
                4'hD: begin e.cyc = 3 * j + 2; e.port = imm; e.val = ma; exp_ev.push_back(e); end
`ifdef CPU_IN_EN
                4'hE: begin exp_do.push_back(3 * j + 2); ma = dev_data; mz = (ma == 0); end
`endif
                4'hF: begin exp_halted = 1; exp_halt_addr = imm; break; end
                default: ;
            endcase
        end
    endtask

    task automatic do_reset(input bit load);
        @(negedge clk);
        reset_bar = 1'b0;
        if (load) for (int i = 0; i < 256; i++) dut.rom[i] = prog[i];
        @(negedge clk);
        reset_bar = 1'b1;
    endtask

    task automatic run_prog(input int ncyc);
        ev_t e;
        got_ev.delete(); got_do.delete(); nodrive_err = 0; excl_err = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (DI) begin
                e.cyc = k; e.port = addr; e.val = bus;
                got_ev.push_back(e);
            end else if (bus !== dev_data) nodrive_err++;
            if (DO) got_do.push_back(k);
            if (DI && DO) excl_err++;
        end
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, " out_count"}, got_ev.size(), exp_ev.size());
        n = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++)
            check({tag, " out_event"}, {got_ev[i].cyc, got_ev[i].port, got_ev[i].val},
                  {exp_ev[i].cyc, exp_ev[i].port, exp_ev[i].val});
        check({tag, " in_count"}, got_do.size(), exp_do.size());
        n = (got_do.size() < exp_do.size()) ? got_do.size() : exp_do.size();
        for (int i = 0; i < n; i++) check({tag, " in_cycle"}, got_do[i], exp_do[i]);
        check({tag, " bus_released"}, nodrive_err, 0);
        check({tag, " di_do_excl"}, excl_err, 0);
        if (exp_halted) check({tag, " halt_addr"}, addr, exp_halt_addr);
    endtask

    task automatic run_test(input string tag);
        do_reset(1);
        model(steps);
        run_prog(3 * steps + 12);
        compare(tag);
    endtask

    initial begin
        @(negedge clk);
        check("reset addr", addr, 16'h0000);
        check("reset DI", DI, 1'b0);
        check("reset DO", DO, 1'b0);
        check("reset bus", bus, dev_data);

        clear_prog();
        prog[0] = ins(4'h1, 0); prog[1] = ins(4'hD, 0); prog[2] = ins(4'h2, 1);
        prog[3] = ins(4'h4, 25); prog[4] = ins(4'hC, 1); prog[5] = ins(4'hF, 0);
        do_reset(0);
        model(steps);
        run_prog(2000);
        compare("builtin");
        check("builtin count", got_ev.size(), 25);
        for (int i = 0; i < 25 && i < got_ev.size(); i++)
            check("builtin value", {got_ev[i].port, got_ev[i].val}, {16'h0000, 16'(i)});

        do_reset(0);
        run_prog(17);
        check("midout DI", DI, 1'b1);
        check("midout bus", bus, 16'h0001);
        reset_bar = 1'b0;
        #1;
        check("abort DI", DI, 1'b0);
        check("abort DO", DO, 1'b0);
        check("abort addr", addr, 16'h0000);
        check("abort bus", bus, dev_data);
        @(negedge clk);
        reset_bar = 1'b1;
        run_prog(2000);
        compare("restart");
        if (got_ev.size() > 0) check("restart first", got_ev[0].val, 16'h0000);

        clear_prog();
        prog[0] = ins(4'h1, 0); prog[1] = ins(4'h3, 1); prog[2] = ins(4'hD, 3); prog[3] = ins(4'hF, 0);
        run_test("subi_wrap");
        if (got_ev.size() > 0) check("subi_wrap lit", {got_ev[0].port, got_ev[0].val}, {16'h0003, 16'hFFFF});

        clear_prog();
        prog[0] = 16'h1005; prog[1] = 16'h600A; prog[2] = 16'h1000; prog[3] = 16'h700A;
        prog[4] = 16'h700A; prog[5] = 16'hD001; prog[6] = 16'hB000; prog[7] = 16'hF000;
        run_test("ram_add");
        check("ram_add count", got_ev.size(), 1);
        if (got_ev.size() > 0) check("ram_add lit", {got_ev[0].port, got_ev[0].val}, {16'h0001, 16'h000A});

        clear_prog();
        prog[0] = 16'h2001; prog[1] = 16'h4002; prog[2] = 16'hB004; prog[3] = 16'hA0FF;
        prog[4] = 16'hD005; prog[5] = 16'hF000; prog[255] = 16'hD006;
        run_test("pc_wrap");
        check("pc_wrap count", got_ev.size(), 2);
        if (got_ev.size() > 1) begin
            check("pc_wrap ev0", {got_ev[0].port, got_ev[0].val}, {16'h0006, 16'h0001});
            check("pc_wrap ev1", {got_ev[1].port, got_ev[1].val}, {16'h0005, 16'h0002});
        end

        dev_data = 16'h1234;
        clear_prog();
        prog[0] = ins(4'hE, 2); prog[1] = ins(4'hD, 0); prog[2] = ins(4'hF, 0);
        run_test("in_port");
`ifdef CPU_IN_EN
        check("in_port do_count", got_do.size(), 1);
        if (got_ev.size() > 0) check("in_port lit", got_ev[0].val, 16'h1234);
`else
        check("in_port do_count", got_do.size(), 0);
        if (got_ev.size() > 0) check("in_port lit", got_ev[0].val, 16'h0000);
`endif

        for (int p = 0; p < 6; p++) begin
            int idx;
            logic [3:0] op;
            logic [11:0] imm;
            clear_prog();
            dev_data = 16'($urandom);
            idx = 0;
            for (int r = 0; r < 8; r++) begin
                prog[idx] = ins(4'h1, 12'($urandom_range(0, 3))); idx++;
                prog[idx] = ins(4'h6, {4'($urandom), 8'(r)}); idx++;
            end
            for (int b = 0; b < 20; b++) begin
                op = 4'($urandom_range(0, 14));
                if (op >= 4'h5 && op <= 4'h9) imm = {4'($urandom), 5'd0, 3'($urandom)};
                else if (op >= 4'hA && op <= 4'hC) imm = {4'($urandom), 8'($urandom_range(36, idx + 1))};
                else if ($urandom_range(0, 1) == 0) imm = 12'($urandom_range(0, 3));
                else imm = 12'($urandom);
                prog[idx] = ins(op, imm);
                idx++;
            end
            prog[idx] = ins(4'hF, 12'($urandom));
            run_test("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
